riscv_mc_ctrl: RTL and testbench

- Multi-cycle sequencer for the single-issue core. Steps each instruction through fetch, decode, execute, memory and writeback, and drives the execute stage, register file, PC and instruction register enables.
- Runs the instruction- and data-memory request/acknowledge handshakes.
- Detects illegal instructions and memory timeouts, and counts retired instructions.

---
 rtl/riscv_mc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle sequencer for the single-issue core: fetch/decode/exec/mem/wb stepping,
// memory handshakes with timeout trap, illegal-op trap and retired-instruction count.
//
// state  | meaning
// IDLE   | waiting for en_i
// FETCH  | imem request outstanding, IR loads on ack
// DECODE | classify instruction, trap on illegal
// EXEC   | execute; BRANCH retires here
// MEM    | dmem request outstanding; STORE retires on ack
// WB     | register write and PC update, retire
// TRAP   | halted until reset
module riscv_mc_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic [2:0]  op_class_i,
    input  logic        imem_ack_i,
    input  logic        dmem_ack_i,
    output logic        imem_req_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic        ir_we_o,
    output logic        pc_we_o,
    output logic        pc_sel_o,
    output logic        reg_we_o,
    output logic [1:0]  wb_sel_o,
    output logic [2:0]  state_o,
    output logic        halt_o,
    output logic [1:0]  trap_cause_o,
    output logic        retire_o,
    output logic [31:0] instret_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_LOAD   = 3'd1;
    localparam logic [2:0] C_STORE  = 3'd2;
    localparam logic [2:0] C_BRANCH = 3'd3;
    localparam logic [2:0] C_JAL    = 3'd4;
    localparam logic [2:0] C_JALR   = 3'd5;
    localparam logic [2:0] C_ILL    = 3'd7;

    localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cls;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_tmo;
    logic              w_waiting;
    logic              r_halt;
    logic [1:0]        r_cause;
    logic [1:0]        w_cause_nxt;
    logic [31:0]       r_instret;

    // w_tmo fires on the cycle that would make the count reach TIMEOUT; an ack that cycle wins
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_tmo     = (w_cnt_inc == TMO_CNT);
    assign w_waiting = ((r_state == S_FETCH) && !imem_ack_i) ||
                       ((r_state == S_MEM) && !dmem_ack_i);

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 1'b0;
        reg_we_o    = 1'b0;
        wb_sel_o    = 2'd0;
        retire_o    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (en_i) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_we_o     = 1'b1;
                    w_state_nxt = S_DECODE;
                end else if (w_tmo) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = 2'd1;
                end
            end
            S_DECODE: begin
                if (op_class_i == C_ILL) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = 2'd3;
                end else begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cls == C_BRANCH) begin
                    pc_we_o     = 1'b1;
                    retire_o    = 1'b1;
                    w_state_nxt = en_i ? S_FETCH : S_IDLE;
                end else if ((r_cls == C_LOAD) || (r_cls == C_STORE)) begin
                    w_state_nxt = S_MEM;
                end else begin
                    w_state_nxt = S_WB;
                end
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (r_cls == C_STORE);
                if (dmem_ack_i) begin
                    if (r_cls == C_STORE) begin
                        pc_we_o     = 1'b1;
                        retire_o    = 1'b1;
                        w_state_nxt = en_i ? S_FETCH : S_IDLE;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end else if (w_tmo) begin
                    w_state_nxt = S_TRAP;
                    w_cause_nxt = 2'd2;
                end
            end
            S_WB: begin
                reg_we_o    = 1'b1;
                pc_we_o     = 1'b1;
                retire_o    = 1'b1;
                pc_sel_o    = (r_cls == C_JALR);
                if (r_cls == C_LOAD)
                    wb_sel_o = 2'd1;
                else if ((r_cls == C_JAL) || (r_cls == C_JALR))
                    wb_sel_o = 2'd2;
                else
                    wb_sel_o = 2'd0;
                w_state_nxt = en_i ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                w_state_nxt = S_TRAP;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= S_IDLE;
            r_cls     <= 3'd0;
            r_cnt     <= '0;
            r_halt    <= 1'b0;
            r_cause   <= 2'd0;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_halt  <= (w_state_nxt == S_TRAP);
            r_cause <= w_cause_nxt;
            if (r_state == S_DECODE)
                r_cls <= op_class_i;
            if (w_waiting && !w_tmo)
                r_cnt <= w_cnt_inc;
            else
                r_cnt <= '0;
            if (retire_o)
                r_instret <= r_instret + 32'd1;
        end
    end

    assign state_o      = r_state;
    assign halt_o       = r_halt;
    assign trap_cause_o = r_cause;
    assign instret_o    = r_instret;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// Scoreboard bench for riscv_mc_ctrl: expected retire records are queued when an
// instruction is launched and compared when the DUT pulses retire_o.
module tb_riscv_mc_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic [2:0]  op_class_i = 3'd0;
    logic        imem_ack_i = 1'b0;
    logic        dmem_ack_i = 1'b0;
    logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, reg_we_o;
    logic [1:0]  wb_sel_o;
    logic [2:0]  state_o;
    logic        halt_o;
    logic [1:0]  trap_cause_o;
    logic        retire_o;
    logic [31:0] instret_o;
    logic [9:0]  w_strb;

    always #5 clk_i = ~clk_i;

    riscv_mc_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(en_i), .op_class_i(op_class_i),
        .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
        .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .reg_we_o(reg_we_o),
        .wb_sel_o(wb_sel_o), .state_o(state_o), .halt_o(halt_o),
        .trap_cause_o(trap_cause_o), .retire_o(retire_o), .instret_o(instret_o)
    );

    assign w_strb = {imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o,
                     pc_sel_o, reg_we_o, wb_sel_o, retire_o};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  state;
        logic        reg_we;
        logic        pc_sel;
        logic [1:0]  wb_sel;
        logic [31:0] instret;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] n_ret = 32'd0;

    always @(negedge clk_i) begin
        #2;
        if (retire_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_retire", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("ret_state",   state_o,   mon_e.state);
                chk("ret_pc_we",   pc_we_o,   32'd1);
                chk("ret_reg_we",  reg_we_o,  mon_e.reg_we);
                chk("ret_pc_sel",  pc_sel_o,  mon_e.pc_sel);
                chk("ret_wb_sel",  wb_sel_o,  mon_e.wb_sel);
                chk("ret_instret", instret_o, mon_e.instret);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk_i);
        rst_n_i = 1'b0; en_i = 1'b0; imem_ack_i = 1'b0; dmem_ack_i = 1'b0; op_class_i = 3'd0;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("rst_state", state_o, 32'd0);
        chk("rst_strb", w_strb, 32'd0);
        chk("rst_halt", halt_o, 32'd0);
        chk("rst_cause", trap_cause_o, 32'd0);
        chk("rst_instret", instret_o, 32'd0);
        rst_n_i = 1'b1;
        n_ret = 32'd0;
        sb_q.delete();
    endtask

    task automatic go();
        @(negedge clk_i);
        en_i = 1'b1;
        #1 chk("go_idle", state_o, 32'd0);
    endtask

    // Drives one instruction starting at its first FETCH cycle; iw/dw are no-ack cycles.
    task automatic exec_instr(input logic [2:0] cls, input int iw, input int dw, input logic en_ret);
        exp_t e;
        int   nreq;
        e.state   = (cls == 3'd3) ? 3'd3 : (cls == 3'd2) ? 3'd4 : 3'd5;
        e.reg_we  = !((cls == 3'd2) || (cls == 3'd3));
        e.pc_sel  = (cls == 3'd5);
        e.wb_sel  = (cls == 3'd1) ? 2'd1 : ((cls == 3'd4) || (cls == 3'd5)) ? 2'd2 : 2'd0;
        e.instret = n_ret;
        sb_q.push_back(e);
        n_ret = n_ret + 32'd1;
        for (int i = 0; i < iw; i++) begin
            @(negedge clk_i);
            imem_ack_i = 1'b0; dmem_ack_i = 1'b0;
            #1;
            chk("f_state", state_o, 32'd1);
            chk("f_req", imem_req_o, 32'd1);
            chk("f_irwe", ir_we_o, 32'd0);
            if (i == 0) chk("f_instret", instret_o, e.instret);
        end
        @(negedge clk_i);
        imem_ack_i = 1'b1; dmem_ack_i = 1'b0;
        #1;
        chk("f_state_ack", state_o, 32'd1);
        chk("f_irwe_ack", ir_we_o, 32'd1);
        chk("f_pcwe", pc_we_o, 32'd0);
        if (iw == 0) chk("f_instret", instret_o, e.instret);
        @(negedge clk_i);
        imem_ack_i = 1'b0; op_class_i = cls;
        #1;
        chk("d_state", state_o, 32'd2);
        chk("d_pcwe", pc_we_o, 32'd0);
        @(negedge clk_i);
        op_class_i = 3'd7;
        if (cls == 3'd3) en_i = en_ret;
        #1;
        chk("e_state", state_o, 32'd3);
        chk("e_pcwe", pc_we_o, {31'd0, cls == 3'd3});
        if ((cls == 3'd1) || (cls == 3'd2)) begin
            nreq = 0;
            for (int i = 0; i < dw; i++) begin
                @(negedge clk_i);
                dmem_ack_i = 1'b0;
                #1;
                chk("m_state", state_o, 32'd4);
                chk("m_we", dmem_we_o, {31'd0, cls == 3'd2});
                chk("m_pcwe", pc_we_o, 32'd0);
                nreq += int'(dmem_req_o);
            end
            @(negedge clk_i);
            dmem_ack_i = 1'b1;
            if (cls == 3'd2) en_i = en_ret;
            #1;
            chk("m_we_ack", dmem_we_o, {31'd0, cls == 3'd2});
            nreq += int'(dmem_req_o);
            chk("m_req_cycles", nreq, dw + 1);
        end
        if ((cls != 3'd2) && (cls != 3'd3)) begin
            @(negedge clk_i);
            dmem_ack_i = 1'b0; en_i = en_ret;
            #1;
            chk("w_state", state_o, 32'd5);
            chk("w_regwe", reg_we_o, 32'd1);
        end
    endtask

    task automatic fetch_dec(input logic [2:0] cls);
        @(negedge clk_i);
        imem_ack_i = 1'b1;
        #1 chk("fd_irwe", ir_we_o, 32'd1);
        @(negedge clk_i);
        imem_ack_i = 1'b0; op_class_i = cls;
        #1 chk("fd_state", state_o, 32'd2);
    endtask

    initial begin
        do_reset();
        repeat (5) begin
            @(negedge clk_i);
            #1;
            chk("idle_state", state_o, 32'd0);
            chk("idle_strb", w_strb, 32'd0);
        end

        // directed: ALU, LOAD, STORE, BRANCH, JAL, LUI, JALR with en dropped in WB
        go();
        exec_instr(3'd0, 0, 0, 1'b1);
        exec_instr(3'd1, 1, 3, 1'b1);
        exec_instr(3'd2, 0, 0, 1'b1);
        exec_instr(3'd3, 2, 0, 1'b1);
        exec_instr(3'd4, 0, 0, 1'b1);
        exec_instr(3'd6, 3, 0, 1'b1);
        exec_instr(3'd5, 0, 0, 1'b0);
        repeat (3) begin
            @(negedge clk_i);
            #1;
            chk("post_jalr_idle", state_o, 32'd0);
            chk("post_jalr_instret", instret_o, n_ret);
        end
        chk("instret_7", instret_o, 32'd7);

        // imem timeout: four unacked cycles trap; late ack in TRAP ignored
        do_reset();
        go();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1;
            chk("to_i_state", state_o, 32'd1);
            chk("to_i_req", imem_req_o, 32'd1);
        end
        @(negedge clk_i);
        imem_ack_i = 1'b1;
        #1;
        chk("to_i_trap", state_o, 32'd6);
        chk("to_i_halt", halt_o, 32'd1);
        chk("to_i_cause", trap_cause_o, 32'd1);
        chk("to_i_strb", w_strb, 32'd0);
        repeat (2) @(negedge clk_i);
        #1;
        chk("to_i_sticky", state_o, 32'd6);
        chk("to_i_instret", instret_o, 32'd0);
        imem_ack_i = 1'b0;

        // ack on the 4th wait cycle for both memories: no trap
        do_reset();
        go();
        exec_instr(3'd1, 3, 3, 1'b1);
        exec_instr(3'd2, 3, 3, 1'b0);
        @(negedge clk_i);
        #1;
        chk("bnd_state", state_o, 32'd0);
        chk("bnd_halt", halt_o, 32'd0);
        chk("bnd_instret", instret_o, 32'd2);

        // dmem timeout
        do_reset();
        go();
        fetch_dec(3'd1);
        @(negedge clk_i);
        #1 chk("to_d_exec", state_o, 32'd3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            #1 chk("to_d_state", state_o, 32'd4);
        end
        @(negedge clk_i);
        dmem_ack_i = 1'b1;
        #1;
        chk("to_d_trap", state_o, 32'd6);
        chk("to_d_cause", trap_cause_o, 32'd2);
        chk("to_d_strb", w_strb, 32'd0);
        dmem_ack_i = 1'b0;

        // illegal instruction
        do_reset();
        go();
        fetch_dec(3'd7);
        @(negedge clk_i);
        #1;
        chk("ill_state", state_o, 32'd6);
        chk("ill_cause", trap_cause_o, 32'd3);
        chk("ill_halt", halt_o, 32'd1);
        do_reset();

        // random legal instruction stream
        go();
        for (int k = 0; k < 24; k++)
            exec_instr(3'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), (k != 23));
        @(negedge clk_i);
        #1;
        chk("rand_idle", state_o, 32'd0);
        chk("rand_instret", instret_o, n_ret);
        @(negedge clk_i);
        #3;
        chk("sb_drain", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
